// File: rtl/spi_input_conditioner_if.sv
// rtl/spi_input_conditioner_if.sv - pin and conditioned-signal bundle for spi_input_conditioner
//
// Purpose: groups the raw SPI pins and the conditioned outputs of the
// SPI input conditioner so they travel as a single port.
// Optional feature macro: SPI_IN_COND_GLITCH_CNT_EN (adds glitchCount).
//
// Signals:
//   sclkIn, csIn, mosiIn        raw asynchronous pins (cs active low)
//   sclkClean, csClean, mosiClean  synchronized + debounced levels
//   sclkPosEdge, sclkNegEdge    one-cycle sclk edge strobes
//   csAssert, csDeassert        one-cycle chip-select edge strobes
//   bitCount[2:0]               sclk rising edges counted in current byte
//   byteDone                    one-cycle strobe after 8th rising edge
//   glitchCount[7:0]            rejected sclk glitches (macro only)
//
// Modports:
//   master - drives the pins, observes conditioned outputs
//   slave  - the conditioner itself
interface spi_input_conditioner_if;
  logic       sclkIn;
  logic       csIn;
  logic       mosiIn;
  logic       sclkClean;
  logic       csClean;
  logic       mosiClean;
  logic       sclkPosEdge;
  logic       sclkNegEdge;
  logic       csAssert;
  logic       csDeassert;
  logic [2:0] bitCount;
  logic       byteDone;
`ifdef SPI_IN_COND_GLITCH_CNT_EN
  logic [7:0] glitchCount;
`endif

  modport master (
    output sclkIn, csIn, mosiIn,
    input  sclkClean, csClean, mosiClean,
    input  sclkPosEdge, sclkNegEdge, csAssert, csDeassert,
    input  bitCount, byteDone
`ifdef SPI_IN_COND_GLITCH_CNT_EN
    , input glitchCount
`endif
  );

  modport slave (
    input  sclkIn, csIn, mosiIn,
    output sclkClean, csClean, mosiClean,
    output sclkPosEdge, sclkNegEdge, csAssert, csDeassert,
    output bitCount, byteDone
`ifdef SPI_IN_COND_GLITCH_CNT_EN
    , output glitchCount
`endif
  );
endinterface

// File: rtl/spi_input_conditioner.sv
// rtl/spi_input_conditioner.sv - SPI pin synchronizer, debouncer, edge detector and bit counter
//
// Purpose: front end of the SPI peripheral. Each raw pin passes through a
// SYNC_STAGES-deep synchronizer and a DEBOUNCE-cycle debouncer. sclk and cs
// level changes become one-cycle strobes; sclk rising edges inside a CS
// frame are counted modulo 8 with a byte-complete strobe.
// Optional feature macro: SPI_IN_COND_GLITCH_CNT_EN (saturating count of
// rejected sclk glitches on bus.glitchCount).
//
// Ports:
//   clk    in  system clock, all state on posedge
//   reset  in  synchronous active-high reset
//   bus    spi_input_conditioner_if.slave (pins in, conditioned signals out)
module spi_input_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 3,
  parameter int CNT_W       = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  spi_input_conditioner_if.slave   bus
);

  // Pin index: 0 = sclk, 1 = cs, 2 = mosi.
  localparam int               LP_NP        = 3;
  localparam logic [CNT_W-1:0] LP_CNT_MAX   = CNT_W'(DEBOUNCE - 1);
  // cs idles high (inactive); sclk and mosi idle low.
  localparam logic [2:0]       LP_CLEAN_RST = 3'b010;

  logic [SYNC_STAGES-1:0] r_sync [LP_NP];
  logic [CNT_W-1:0]       r_cnt  [LP_NP];
  logic [LP_NP-1:0]       r_clean;

  logic                   r_sclk_pos;
  logic                   r_sclk_neg;
  logic                   r_cs_assert;
  logic                   r_cs_deassert;
  logic [2:0]             r_bit_count;
  logic                   r_byte_done;

  logic [LP_NP-1:0]       w_pin;
  logic [LP_NP-1:0]       w_s;
  logic [LP_NP-1:0]       w_accept;

  always_comb begin
    w_pin    = {bus.mosiIn, bus.csIn, bus.sclkIn};
    w_s      = '0;
    w_accept = '0;
    for (int i = 0; i < LP_NP; i++) begin
      w_s[i]      = r_sync[i][SYNC_STAGES-1];
      // The synced level has differed from clean for DEBOUNCE edges,
      // counting this one: take it now.
      w_accept[i] = (w_s[i] != r_clean[i]) && (r_cnt[i] == LP_CNT_MAX);
    end
  end

  // Synchronizers and debouncers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LP_NP; i++) begin
        r_sync[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_clean <= LP_CLEAN_RST;
    end else begin
      for (int i = 0; i < LP_NP; i++) begin
        r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_pin[i]};
        if (w_s[i] == r_clean[i]) begin
          r_cnt[i] <= '0;
        end else if (w_accept[i]) begin
          r_clean[i] <= w_s[i];
          r_cnt[i]   <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Edge strobes, registered on the same edge that updates the clean level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclk_pos    <= 1'b0;
      r_sclk_neg    <= 1'b0;
      r_cs_assert   <= 1'b0;
      r_cs_deassert <= 1'b0;
    end else begin
      r_sclk_pos    <= w_accept[0] &  w_s[0];
      r_sclk_neg    <= w_accept[0] & ~w_s[0];
      r_cs_assert   <= w_accept[1] & ~w_s[1];
      r_cs_deassert <= w_accept[1] &  w_s[1];
    end
  end

  // Bit counter. Uses the registered clean cs and sclk strobe, so an sclk
  // strobe coinciding with csAssert is counted while one coinciding with
  // csDeassert (clean cs already 1) is not.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_count <= '0;
      r_byte_done <= 1'b0;
    end else if (r_clean[1]) begin
      r_bit_count <= '0;
      r_byte_done <= 1'b0;
    end else if (r_sclk_pos) begin
      r_bit_count <= r_bit_count + 3'd1;
      r_byte_done <= (r_bit_count == 3'd7);
    end else begin
      r_byte_done <= 1'b0;
    end
  end

`ifdef SPI_IN_COND_GLITCH_CNT_EN
  logic [7:0] r_glitch_count;
  logic       w_glitch;

  // sclk started to move but returned to its clean level before acceptance.
  assign w_glitch = (r_cnt[0] != '0) && (w_s[0] == r_clean[0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_glitch_count <= '0;
    end else if (w_glitch && (r_glitch_count != 8'hFF)) begin
      r_glitch_count <= r_glitch_count + 8'd1;
    end
  end

  assign bus.glitchCount = r_glitch_count;
`endif

  assign bus.sclkClean   = r_clean[0];
  assign bus.csClean     = r_clean[1];
  assign bus.mosiClean   = r_clean[2];
  assign bus.sclkPosEdge = r_sclk_pos;
  assign bus.sclkNegEdge = r_sclk_neg;
  assign bus.csAssert    = r_cs_assert;
  assign bus.csDeassert  = r_cs_deassert;
  assign bus.bitCount    = r_bit_count;
  assign bus.byteDone    = r_byte_done;

endmodule
